// File: rtl/mem_arbiter.sv
// mem_arbiter: D-priority two-requester sequencer onto one memory port.
// Define ARB_TIMEOUT_EN to add the abort counter and sticky error flag.
module mem_arbiter #(
  parameter int DATAWIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic                 ARB_Clk_In,
  input  logic                 ARB_Reset_In,
  input  logic                 ARB_I_Req_In,
  input  logic [DATAWIDTH-1:0] ARB_I_Addr_InBUS,
  output logic [DATAWIDTH-1:0] ARB_I_Rdata_OutBUS,
  output logic                 ARB_I_Valid_Out,
  input  logic                 ARB_D_Req_In,
  input  logic                 ARB_D_Write_In,
  input  logic [DATAWIDTH-1:0] ARB_D_Addr_InBUS,
  input  logic [DATAWIDTH-1:0] ARB_D_Wdata_InBUS,
  input  logic [3:0]           ARB_D_Byteen_InBUS,
  output logic [DATAWIDTH-1:0] ARB_D_Rdata_OutBUS,
  output logic                 ARB_D_Valid_Out,
  output logic                 ARB_M_Req_Out,
  output logic                 ARB_M_Write_Out,
  output logic [DATAWIDTH-1:0] ARB_M_Addr_OutBUS,
  output logic [DATAWIDTH-1:0] ARB_M_Wdata_OutBUS,
  output logic [3:0]           ARB_M_Byteen_OutBUS,
  input  logic                 ARB_M_Ack_In,
  input  logic                 ARB_M_Rvalid_In,
  input  logic [DATAWIDTH-1:0] ARB_M_Rdata_InBUS,
  output logic [1:0]           ARB_Grant_OutBUS,
  output logic                 ARB_Busy_Out,
  output logic                 ARB_Error_Out
);

  typedef enum logic [2:0] {
    S_IDLE, S_I_ADDR, S_I_WAIT, S_D_ADDR, S_D_WAIT
  } state_e;

  if ((1 << TO_WIDTH) <= TIMEOUT_CYCLES) begin : g_to_width_chk
    $error("TO_WIDTH too narrow for TIMEOUT_CYCLES");
  end

  state_e               state_q;
  logic                 m_req_q, m_write_q;
  logic [DATAWIDTH-1:0] m_addr_q, m_wdata_q;
  logic [3:0]           m_be_q;
  logic [DATAWIDTH-1:0] i_rdata_q, d_rdata_q;
  logic                 i_valid_q, d_valid_q;
  logic [1:0]           grant_q;

  logic i_take, d_take, in_addr, in_wait, own_d, done;

  // A requester still showing its completion pulse is not re-granted.
  always_comb begin
    i_take  = ARB_I_Req_In & ~i_valid_q;
    d_take  = ARB_D_Req_In & ~d_valid_q;
    in_addr = (state_q == S_I_ADDR) | (state_q == S_D_ADDR);
    in_wait = (state_q == S_I_WAIT) | (state_q == S_D_WAIT);
    own_d   = (state_q == S_D_ADDR) | (state_q == S_D_WAIT);
    done    = (in_addr & ARB_M_Ack_In & (m_write_q | ARB_M_Rvalid_In))
            | (in_wait & ARB_M_Rvalid_In);
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [TO_WIDTH-1:0] TO_LIMIT =
    TO_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [TO_WIDTH-1:0] to_cnt_q;
  logic                err_q;
`endif

  always_ff @(posedge ARB_Clk_In or posedge ARB_Reset_In) begin
    if (ARB_Reset_In) begin
      state_q   <= S_IDLE;
      m_req_q   <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_be_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      grant_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q  <= (state_q == S_IDLE) ? '0 : to_cnt_q + 1'b1;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (d_take) begin
            state_q   <= S_D_ADDR;
            m_req_q   <= 1'b1;
            m_write_q <= ARB_D_Write_In;
            m_addr_q  <= ARB_D_Addr_InBUS;
            m_wdata_q <= ARB_D_Wdata_InBUS;
            m_be_q    <= ARB_D_Byteen_InBUS;
            grant_q   <= 2'b10;
          end else if (i_take) begin
            state_q   <= S_I_ADDR;
            m_req_q   <= 1'b1;
            m_write_q <= 1'b0;
            m_addr_q  <= ARB_I_Addr_InBUS;
            m_wdata_q <= '0;
            m_be_q    <= 4'b1111;
            grant_q   <= 2'b01;
          end
        end
        S_I_ADDR, S_D_ADDR, S_I_WAIT, S_D_WAIT: begin
          if (done) begin
            state_q <= S_IDLE;
            m_req_q <= 1'b0;
            grant_q <= '0;
            if (own_d) begin
              d_valid_q <= 1'b1;
              if (!m_write_q) d_rdata_q <= ARB_M_Rdata_InBUS;
            end else begin
              i_valid_q <= 1'b1;
              i_rdata_q <= ARB_M_Rdata_InBUS;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (to_cnt_q == TO_LIMIT) begin
            state_q <= S_IDLE;
            m_req_q <= 1'b0;
            grant_q <= '0;
            err_q   <= 1'b1;
            if (own_d) begin
              d_valid_q <= 1'b1;
              d_rdata_q <= '0;
            end else begin
              i_valid_q <= 1'b1;
              i_rdata_q <= '0;
            end
          end
`endif
          else if (in_addr && ARB_M_Ack_In) begin
            state_q <= own_d ? S_D_WAIT : S_I_WAIT;
            m_req_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ARB_I_Rdata_OutBUS  = i_rdata_q;
  assign ARB_I_Valid_Out     = i_valid_q;
  assign ARB_D_Rdata_OutBUS  = d_rdata_q;
  assign ARB_D_Valid_Out     = d_valid_q;
  assign ARB_M_Req_Out       = m_req_q;
  assign ARB_M_Write_Out     = m_write_q;
  assign ARB_M_Addr_OutBUS   = m_addr_q;
  assign ARB_M_Wdata_OutBUS  = m_wdata_q;
  assign ARB_M_Byteen_OutBUS = m_be_q;
  assign ARB_Grant_OutBUS    = grant_q;
  assign ARB_Busy_Out        = (state_q != S_IDLE);
`ifdef ARB_TIMEOUT_EN
  assign ARB_Error_Out       = err_q;
`else
  assign ARB_Error_Out       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a rdata scoreboard per requester.
// Timeout steps run only when ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        m_ack, m_rvalid;
  logic [31:0] m_rdata;
  logic [31:0] i_rdata, d_rdata;
  logic        i_valid, d_valid;
  logic        m_req, m_write;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic [1:0]  grant;
  logic        busy, err;

  int checks = 0;
  int errors = 0;
  int mtx = 0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  logic iv_prev = 1'b0;
  logic dv_prev = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .ARB_Clk_In          (clk),
    .ARB_Reset_In        (rst),
    .ARB_I_Req_In        (i_req),
    .ARB_I_Addr_InBUS    (i_addr),
    .ARB_I_Rdata_OutBUS  (i_rdata),
    .ARB_I_Valid_Out     (i_valid),
    .ARB_D_Req_In        (d_req),
    .ARB_D_Write_In      (d_we),
    .ARB_D_Addr_InBUS    (d_addr),
    .ARB_D_Wdata_InBUS   (d_wdata),
    .ARB_D_Byteen_InBUS  (d_be),
    .ARB_D_Rdata_OutBUS  (d_rdata),
    .ARB_D_Valid_Out     (d_valid),
    .ARB_M_Req_Out       (m_req),
    .ARB_M_Write_Out     (m_write),
    .ARB_M_Addr_OutBUS   (m_addr),
    .ARB_M_Wdata_OutBUS  (m_wdata),
    .ARB_M_Byteen_OutBUS (m_be),
    .ARB_M_Ack_In        (m_ack),
    .ARB_M_Rvalid_In     (m_rvalid),
    .ARB_M_Rdata_InBUS   (m_rdata),
    .ARB_Grant_OutBUS    (grant),
    .ARB_Busy_Out        (busy),
    .ARB_Error_Out       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk)
    if (!rst && m_req && m_ack) mtx <= mtx + 1;

  // Every Valid pulse must match a queued expectation and be one cycle wide.
  always @(negedge clk) begin
    if (i_valid) begin
      chk("i_pulse_width", {31'b0, iv_prev}, 32'd0);
      checks++;
      assert (iq.size() > 0) else begin
        errors++;
        $error("FAIL i_spurious obs=%0d exp=>0", iq.size());
      end
      if (iq.size() > 0) chk("i_rdata", i_rdata, iq.pop_front());
    end
    if (d_valid) begin
      chk("d_pulse_width", {31'b0, dv_prev}, 32'd0);
      checks++;
      assert (dq.size() > 0) else begin
        errors++;
        $error("FAIL d_spurious obs=%0d exp=>0", dq.size());
      end
      if (dq.size() > 0) chk("d_rdata", d_rdata, dq.pop_front());
    end
    iv_prev <= i_valid;
    dv_prev <= d_valid;
  end

  initial begin
    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    m_ack = 0; m_rvalid = 0; m_rdata = 0;
    step(); step();
    chk("rst_m_req", m_req, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_valids", {i_valid, d_valid}, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;
    step();

    // fetch, zero-wait memory
    i_req = 1; i_addr = 32'h10;
    m_ack = 1; m_rvalid = 1; m_rdata = 32'h0050_0093;
    iq.push_back(32'h0050_0093);
    step();
    chk("f_m_req", m_req, 1);
    chk("f_m_addr", m_addr, 32'h10);
    chk("f_m_be", m_be, 4'hF);
    chk("f_m_write", m_write, 0);
    chk("f_grant", grant, 2'b01);
    chk("f_busy", busy, 1);
    step();
    chk("f_i_valid", i_valid, 1);
    step();
    i_req = 0; m_ack = 0; m_rvalid = 0;
    chk("f_idle_busy", busy, 0);
    chk("f_idle_m_req", m_req, 0);
    chk("f_mtx", mtx, 1);

    // simultaneous D and I: D first
    d_req = 1; d_we = 0; d_addr = 32'h200;
    d_wdata = 32'h1111_2222; d_be = 4'hF;
    i_req = 1; i_addr = 32'h44;
    m_ack = 1; m_rvalid = 1; m_rdata = 32'hAAAA_0001;
    dq.push_back(32'hAAAA_0001);
    step();
    chk("p_grant_d", grant, 2'b10);
    chk("p_m_addr_d", m_addr, 32'h200);
    step();
    chk("p_d_valid", d_valid, 1);
    chk("p_grant_idle", grant, 0);
    d_req = 0;
    m_rdata = 32'hBBBB_0002;
    iq.push_back(32'hBBBB_0002);
    step();
    chk("p_grant_i", grant, 2'b01);
    chk("p_m_addr_i", m_addr, 32'h44);
    chk("p_m_wdata_i", m_wdata, 0);
    chk("p_m_be_i", m_be, 4'hF);
    step();
    chk("p_i_valid", i_valid, 1);
    chk("p_d_quiet", d_valid, 0);
    i_req = 0; m_ack = 0; m_rvalid = 0;
    step();

    // store with ack after 3 wait cycles
    d_req = 1; d_we = 1; d_addr = 32'h100;
    d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    dq.push_back(32'hAAAA_0001);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("s_m_req", m_req, 1);
      chk("s_m_write", m_write, 1);
      chk("s_m_addr", m_addr, 32'h100);
      chk("s_m_wdata", m_wdata, 32'hDEAD_BEEF);
      chk("s_m_be", m_be, 4'b0011);
      if (k == 3) m_ack = 1;
      step();
    end
    chk("s_d_valid", d_valid, 1);
    chk("s_m_req_off", m_req, 0);
    m_ack = 0; d_req = 0;
    step();

    // load: ack in cycle 1, rvalid 4 cycles later
    d_req = 1; d_we = 0; d_addr = 32'h300; m_ack = 1;
    step();
    chk("l_m_req", m_req, 1);
    step();
    m_ack = 0;
    for (int k = 0; k < 4; k++) begin
      chk("l_wait_m_req", m_req, 0);
      chk("l_wait_busy", busy, 1);
      chk("l_wait_grant", grant, 2'b10);
      if (k == 1) m_ack = 1;
      if (k == 2) m_ack = 0;
      if (k == 3) begin
        m_rvalid = 1; m_rdata = 32'h1234_5678;
        dq.push_back(32'h1234_5678);
      end
      step();
    end
    chk("l_d_valid", d_valid, 1);
    m_rvalid = 0; d_req = 0;
    step();
    m_rvalid = 1; m_rdata = 32'hFFFF_0000;
    step();
    m_rvalid = 0;
    chk("l_idle_busy", busy, 0);
    chk("l_idle_d_rdata", d_rdata, 32'h1234_5678);
    chk("l_idle_i_rdata", i_rdata, 32'hBBBB_0002);

    // asynchronous reset while in D_WAIT
    d_req = 1; d_we = 0; d_addr = 32'h400; m_ack = 1;
    step();
    step();
    m_ack = 0;
    chk("r_busy_wait", busy, 1);
    i_req = 1; i_addr = 32'h80;
    #2 rst = 1'b1;
    #1;
    chk("r_m_req", m_req, 0);
    chk("r_grant", grant, 0);
    chk("r_busy", busy, 0);
    chk("r_d_valid", d_valid, 0);
    d_req = 0;
    step();
    rst = 1'b0;
    m_ack = 1; m_rvalid = 1; m_rdata = 32'h0BAD_F00D;
    iq.push_back(32'h0BAD_F00D);
    chk("r_d_rdata_clr", d_rdata, 0);
    step();
    chk("r_grant_i", grant, 2'b01);
    chk("r_m_addr_i", m_addr, 32'h80);
    step();
    chk("r_i_valid", i_valid, 1);
    i_req = 0; m_ack = 0; m_rvalid = 0;
    step();

`ifdef ARB_TIMEOUT_EN
    // memory never answers: abort after 8 cycles
    i_req = 1; i_addr = 32'h20;
    iq.push_back(32'h0);
    step();
    for (int k = 0; k < 8; k++) begin
      chk("t_m_req", m_req, 1);
      chk("t_err_low", err, 0);
      step();
    end
    chk("t_i_valid", i_valid, 1);
    chk("t_err_set", err, 1);
    chk("t_m_req_off", m_req, 0);
    i_req = 0;
    step();
    chk("t_err_sticky", err, 1);
    d_req = 1; d_we = 0; d_addr = 32'h500;
    m_ack = 1; m_rvalid = 1; m_rdata = 32'h5555_AAAA;
    dq.push_back(32'h5555_AAAA);
    step();
    step();
    chk("t_next_valid", d_valid, 1);
    chk("t_err_kept", err, 1);
    d_req = 0; m_ack = 0; m_rvalid = 0;
    step();
`else
    chk("err_tied0", err, 0);
`endif

    chk("iq_drained", iq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
